// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ both carry HTRANS[1]=1
  function automatic logic trans_active(logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for active transfers
// to unmapped space, zero-wait OKAY otherwise.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      take;

  assign take = HSEL & HREADY & trans_active(HTRANS);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (take) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = take ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and response mux with default slave.
// Optional error counter port: AHB_DECODE_ERRCNT_EN.
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h2000_0000, 32'h1000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic                         HSELDefault,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP
`ifdef AHB_DECODE_ERRCNT_EN
  ,
  output logic [15:0]                  err_count
`endif
);

  logic [NUM_SLAVES:0] sel_q;
  logic                ds_ready;
  logic                ds_resp;
  logic                found;

  // Lowest index wins on overlapping windows
  always_comb begin
    HSEL_S = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found &&
          ((HADDR & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
           SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
        HSEL_S[i] = 1'b1;
        found     = 1'b1;
      end
    end
    HSELDefault = ~found;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      sel_q <= {1'b1, {NUM_SLAVES{1'b0}}};
    else if (HREADY) sel_q <= {HSELDefault, HSEL_S};
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b0;
    HRESP  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        HRDATA = HRDATA | HRDATA_S[i*DATA_W +: DATA_W];
        HREADY = HREADY | HREADYOUT_S[i];
        HRESP  = HRESP | HRESP_S[i];
      end
    end
    if (sel_q[NUM_SLAVES]) begin
      HREADY = HREADY | ds_ready;
      HRESP  = HRESP | ds_resp;
    end
  end

  ahb_default_slave u_default (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSELDefault),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_ready),
    .HRESP     (ds_resp)
  );

`ifdef AHB_DECODE_ERRCNT_EN
  logic [15:0] err_q;
  logic        err_take;

  // HREADY is low in DS_ERR1, so this fires only from IDLE/ERR2
  assign err_take = HREADY & HSELDefault & trans_active(HTRANS);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      err_q <= '0;
    else if (err_take && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Directed self-checking bench for ahb_decode_mux.
// Counter checks are active when AHB_DECODE_ERRCNT_EN is defined.
module tb_ahb_decode_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [1:0]  HSEL_S;
  logic        HSELDefault;
  logic [63:0] HRDATA_S;
  logic [1:0]  HREADYOUT_S;
  logic [1:0]  HRESP_S;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
`ifdef AHB_DECODE_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_decode_mux dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_S      (HSEL_S),
    .HSELDefault (HSELDefault),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
`ifdef AHB_DECODE_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET      = 1'b1;
    HADDR       = 32'h1000_0000;
    HTRANS      = 2'b00;
    HRDATA_S    = {32'hCAFE_F00D, 32'h1111_0000};
    HREADYOUT_S = 2'b11;
    HRESP_S     = 2'b00;
    #12;
    checks++;
    if (HREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_hready got %b exp 1", HREADY);
    end
    checks++;
    if (HRESP !== 1'b0) begin
      errors++;
      $display("FAIL reset_hresp got %b exp 0", HRESP);
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_hrdata got %h exp 0", HRDATA);
    end
`ifdef AHB_DECODE_ERRCNT_EN
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_errcnt got %0d exp 0", err_count);
    end
`endif
    step();
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_decode();
    logic [31:0] a [3];
    logic [2:0]  e [3];
    a = '{32'h1000_0040, 32'h2FFF_FFFC, 32'h3000_0000};
    e = '{3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      HADDR = a[i];
      #1;
      checks++;
      if ({HSELDefault, HSEL_S} !== e[i]) begin
        errors++;
        $display("FAIL decode_%h got %b exp %b",
                 a[i], {HSELDefault, HSEL_S}, e[i]);
      end
    end
  endtask

  task automatic test_mux();
    HADDR  = 32'h2000_0000;
    HTRANS = 2'b10;
    step();
    HREADYOUT_S = 2'b01;
    HTRANS      = 2'b00;
    HADDR       = 32'h1000_0000;
    #1;
    checks++;
    if (HREADY !== 1'b0) begin
      errors++;
      $display("FAIL mux_stall_hready got %b exp 0", HREADY);
    end
    checks++;
    if (HSEL_S !== 2'b01) begin
      errors++;
      $display("FAIL mux_stall_hsel got %b exp 01", HSEL_S);
    end
    step();
    HREADYOUT_S = 2'b11;
    #1;
    checks++;
    if (HRDATA !== 32'hCAFE_F00D || HREADY !== 1'b1) begin
      errors++;
      $display("FAIL mux_data got %h/%b exp cafef00d/1",
               HRDATA, HREADY);
    end
    step();
    HRESP_S = 2'b01;
    #1;
    checks++;
    if (HRDATA !== 32'h1111_0000 || HRESP !== 1'b1) begin
      errors++;
      $display("FAIL mux_slave0 got %h/%b exp 11110000/1",
               HRDATA, HRESP);
    end
    HRESP_S = 2'b00;
    #1;
  endtask

  task automatic test_error();
    HADDR  = 32'h3000_0000;
    HTRANS = 2'b10;
    step();
    HADDR  = 32'h1000_0000;
    HTRANS = 2'b00;
    #1;
    checks++;
    if (HREADY !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL err1 got rdy %b resp %b data %h exp 0 1 0",
               HREADY, HRESP, HRDATA);
    end
    step();
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b1) begin
      errors++;
      $display("FAIL err2 got rdy %b resp %b exp 1 1",
               HREADY, HRESP);
    end
    step();
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL err_okay got rdy %b resp %b exp 1 0",
               HREADY, HRESP);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr [4];
    exp_rr = '{2'b01, 2'b11, 2'b01, 2'b11};
    HRESET = 1'b1;
    #1;
    HRESET = 1'b0;
    step();
    HADDR  = 32'h3000_0000;
    HTRANS = 2'b10;
    step();
    HADDR = 32'h3000_0004;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        HADDR  = 32'h1000_0000;
        HTRANS = 2'b00;
      end
      #1;
      checks++;
      if ({HREADY, HRESP} !== exp_rr[i]) begin
        errors++;
        $display("FAIL b2b_%0d got rdy/resp %b exp %b",
                 i, {HREADY, HRESP}, exp_rr[i]);
      end
      step();
    end
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL b2b_okay got rdy %b resp %b exp 1 0",
               HREADY, HRESP);
    end
`ifdef AHB_DECODE_ERRCNT_EN
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_errcnt got %0d exp 2", err_count);
    end
`endif
  endtask

  task automatic test_idle_unmapped();
    logic [1:0] t [2];
    t = '{2'b00, 2'b01};
    HADDR = 32'h3000_0000;
    for (int i = 0; i < 2; i++) begin
      HTRANS = t[i];
      step();
      checks++;
      if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
        errors++;
        $display("FAIL idle_unmapped_%0d got rdy %b resp %b exp 1 0",
                 i, HREADY, HRESP);
      end
    end
    HTRANS = 2'b00;
    step();
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL idle_stay got rdy %b resp %b exp 1 0",
               HREADY, HRESP);
    end
  endtask

  task automatic test_reset_mid_error();
    HADDR  = 32'h3000_0000;
    HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    #1;
    checks++;
    if (HREADY !== 1'b0 || HRESP !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_err1 got rdy %b resp %b exp 0 1",
               HREADY, HRESP);
    end
    HRESET = 1'b1;
    #1;
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort got rdy %b resp %b exp 1 0",
               HREADY, HRESP);
    end
`ifdef AHB_DECODE_ERRCNT_EN
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_errcnt got %0d exp 0", err_count);
    end
`endif
    #2;
    HRESET = 1'b0;
    step();
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got rdy %b resp %b exp 1 0",
               HREADY, HRESP);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mux();
    test_error();
    test_back_to_back();
    test_idle_unmapped();
    test_reset_mid_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_decode_mux.md
AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 2, number of decoded slaves (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, HADDR width.
REQ-003 SHALL have parameter DATA_W, default 32, read-data width.
REQ-004 SHALL have parameter SLAVE_BASE, default {32'h2000_0000, 32'h1000_0000}, packed NUM_SLAVES*ADDR_W base addresses, slave 0 in LSBs.
REQ-005 SHALL have parameter SLAVE_MASK, default {32'hF000_0000, 32'hF000_0000}, packed NUM_SLAVES*ADDR_W compare masks.
REQ-006 SHALL have ports: HCLK in 1 clock; HRESET in 1 reset. One clock; reset is asynchronous and active-high.
REQ-007 SHALL have ports: HADDR in ADDR_W address phase; HTRANS in 2 transfer type.
REQ-008 SHALL have ports: HSEL_S out NUM_SLAVES slave selects; HSELDefault out 1 default-slave select.
REQ-009 SHALL have ports: HRDATA_S in NUM_SLAVES*DATA_W; HREADYOUT_S in NUM_SLAVES; HRESP_S in NUM_SLAVES, all per-slave responses.
REQ-010 SHALL have ports: HRDATA out DATA_W; HREADY out 1; HRESP out 1, muxed response to master and slaves.

Function
REQ-011 Slave i SHALL hit when (HADDR & MASK_i) == BASE_i; combinational, independent of HTRANS.
REQ-012 On multiple hits the lowest index SHALL win; HSEL_S SHALL be one-hot or zero.
REQ-013 HSELDefault SHALL be 1 exactly when no slave hits; HSEL_S|HSELDefault is always one-hot.
REQ-014 Data-phase select register sel_q (NUM_SLAVES+1 bits, one-hot) SHALL load the address-phase select on every rising HCLK with HREADY=1, and hold otherwise.
REQ-015 HRDATA/HREADY/HRESP SHALL come from the slave in sel_q; zero added latency (combinational mux of sel_q).
REQ-016 When sel_q selects default, HRDATA SHALL be 0 and HREADY/HRESP SHALL come from the default-slave FSM.
REQ-017 Default FSM states: DS_IDLE (HREADY=1, HRESP=0), DS_ERR1 (HREADY=0, HRESP=1), DS_ERR2 (HREADY=1, HRESP=1).
REQ-018 DS_IDLE->DS_ERR1 when HREADY=1, HSELDefault=1, HTRANS[1]=1 (NONSEQ/SEQ); else stay.
REQ-019 DS_ERR1->DS_ERR2 unconditionally.
REQ-020 DS_ERR2->DS_ERR1 if the REQ-018 condition holds in that cycle (back-to-back error), else DS_IDLE.
REQ-021 IDLE/BUSY to unmapped address SHALL give zero-wait OKAY.
REQ-022 A slave stalling (HREADYOUT_S=0) SHALL hold sel_q and FSM; HSEL_S still tracks HADDR.

Reset
REQ-023 HRESET=1 SHALL asynchronously set sel_q to default one-hot, FSM to DS_IDLE; HREADY=1, HRESP=0, HRDATA=0 during reset.
REQ-024 Reset mid-error (DS_ERR1/ERR2) SHALL abort to DS_IDLE immediately, no residual HRESP.

Configuration
REQ-025 With AHB_DECODE_ERRCNT_EN defined: extra port err_count out 16, incremented on each DS_IDLE/DS_ERR2->DS_ERR1 transition, saturating at 16'hFFFF, reset to 0.
REQ-026 Without AHB_DECODE_ERRCNT_EN: no err_count port, no counter logic; all else identical.

Structure
REQ-027 Shared package ahb_pkg SHALL hold HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HRESP encodings (OKAY=0, ERROR=1), and the default-FSM state enum.
REQ-028 Default FSM SHALL be sub-module ahb_default_slave (ports HCLK, HRESET, HSEL, HTRANS, HREADY, HREADYOUT, HRESP).

Verification
REQ-029 Decode: HADDR=32'h1000_0040 -> HSEL_S=2'b01; 32'h2FFF_FFFC -> 2'b10; 32'h3000_0000 -> HSELDefault=1.
REQ-030 Mux: NONSEQ to 32'h2000_0000, slave1 HRDATA_S=32'hCAFE_F00D, HREADYOUT_S[1]=0 one cycle -> HREADY=0 one cycle, then HRDATA=32'hCAFE_F00D, HREADY=1.
REQ-031 Error: NONSEQ to 32'h3000_0000 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then OKAY.
REQ-032 Back-to-back: two NONSEQ to unmapped addresses, second accepted in DS_ERR2 -> ERR1,ERR2,ERR1,ERR2, no IDLE cycle; err_count=2 with AHB_DECODE_ERRCNT_EN.
REQ-033 IDLE to 32'h3000_0000 -> HREADY=1, HRESP=0, FSM stays DS_IDLE.
REQ-034 HRESET asserted asynchronously in DS_ERR1 -> HREADY=1, HRESP=0 before next HCLK edge; err_count=0.
